// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus-cycle sequencer: operation codes, T-state
// encoding, the active-low strobe bundle and per-operation decode helpers.
package z80_bus_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      OP_M1     = 3'd0,
      OP_MEM_RD = 3'd1,
      OP_MEM_WR = 3'd2,
      OP_IO_RD  = 3'd3,
      OP_IO_WR  = 3'd4
   } bus_op_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      TW   = 3'd3,
      T3   = 3'd4,
      T4   = 3'd5
   } bus_state_t;

   typedef struct packed {
      logic mreq_l;
      logic iorq_l;
      logic rd_l;
      logic wr_l;
      logic m1_l;
      logic rfsh_l;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = strobe_t'(6'b11_1111);

   function automatic logic op_is_io(bus_op_t op);
      return (op == OP_IO_RD) || (op == OP_IO_WR);
   endfunction

   function automatic logic op_is_rd(bus_op_t op);
      return (op == OP_M1) || (op == OP_MEM_RD) || (op == OP_IO_RD);
   endfunction

   function automatic logic op_is_wr(bus_op_t op);
      return (op == OP_MEM_WR) || (op == OP_IO_WR);
   endfunction

   // Strobes asserted on entry to T1: memory cycles start MREQ (and RD) at once.
   function automatic strobe_t t1_strobes(bus_op_t op);
      strobe_t s;
      s        = STROBE_IDLE;
      s.mreq_l = op_is_io(op);
      s.rd_l   = !((op == OP_M1) || (op == OP_MEM_RD));
      s.m1_l   = (op != OP_M1);
      return s;
   endfunction

endpackage

// File: rtl/z80_rfsh_cnt.sv
// Z80 refresh register R: parallel load, or increment of bits 6:0 with
// bit 7 preserved. A load takes priority over an increment on the same edge.
module z80_rfsh_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld_i,
   input  logic [7:0] r_i,
   input  logic       inc_i,
   output logic [7:0] r_o
);

   logic [7:0] r_q;
   logic [7:0] r_d;

   always_comb begin
      r_d = r_q;
      if (ld_i) begin
         r_d = r_i;
      end else if (inc_i) begin
         r_d = {r_q[7], 7'(r_q[6:0] + 7'd1)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 8'h00;
      end else begin
         r_q <= r_d;
      end
   end

   assign r_o = r_q;

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 external bus-cycle sequencer: T1/T2/[TW]*/T3 with WAIT_L and IO auto-waits.
// Define Z80_BUS_RFSH_EN to extend M1 with the T3/T4 refresh phase and the R register.
module z80_bus_ctrl
   import z80_bus_pkg::*;
#(
   parameter int unsigned IO_AUTO_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [15:0] addr_in,
   input  logic [7:0]  wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rdata,
   output logic [15:0] A_out,
   output logic [7:0]  D_out,
   output logic        D_oe,
   input  logic [7:0]  D_in,
   input  logic        WAIT_L,
   output logic        MREQ_L,
   output logic        IORQ_L,
   output logic        RD_L,
   output logic        WR_L,
   output logic        M1_L,
   output logic        RFSH_L,
   output logic [7:0]  R_out,
   input  logic        ld_R,
   input  logic [7:0]  R_in
);

   localparam logic [1:0] AUTO_W = 2'(IO_AUTO_WAIT);

   bus_state_t          state_q;
   bus_op_t             op_q;
   logic [1:0]          wcnt_q;
   strobe_t             stb_q;
   logic                busy_q;
   logic                done_q;
   logic                doe_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   dout_q;
   logic [ADDR_W-1:0]   a_q;
   logic [7:0]          r_val;
   bus_op_t             op_c;
   logic                auto_pend_c;

   assign op_c        = bus_op_t'(op);
   assign auto_pend_c = op_is_io(op_q) && (wcnt_q < AUTO_W);

`ifdef Z80_BUS_RFSH_EN
   z80_rfsh_cnt u_rfsh (
      .clk   (clk),
      .rst   (rst),
      .ld_i  (ld_R),
      .r_i   (R_in),
      .inc_i (state_q == T4),
      .r_o   (r_val)
   );
`else
   logic unused_rfsh;
   assign r_val       = 8'h00;
   assign unused_rfsh = ^{ld_R, R_in};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_M1;
         wcnt_q  <= 2'd0;
         stb_q   <= STROBE_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         doe_q   <= 1'b0;
         rdata_q <= 8'h00;
         dout_q  <= 8'h00;
         a_q     <= 16'h0000;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  state_q <= T1;
                  op_q    <= op_c;
                  wcnt_q  <= 2'd0;
                  busy_q  <= 1'b1;
                  a_q     <= addr_in;
                  dout_q  <= wdata;
                  doe_q   <= op_is_wr(op_c);
                  stb_q   <= t1_strobes(op_c);
               end
            end
            T1: begin
               state_q      <= T2;
               stb_q.iorq_l <= !op_is_io(op_q);
               stb_q.wr_l   <= !op_is_wr(op_q);
               if (op_is_io(op_q)) begin
                  stb_q.rd_l <= !op_is_rd(op_q);
               end
            end
            // Auto-waits are unconditional; WAIT_L only counts once they are spent.
            T2, TW: begin
               if (auto_pend_c) begin
                  state_q <= TW;
                  wcnt_q  <= wcnt_q + 2'd1;
               end else if (!WAIT_L) begin
                  state_q <= TW;
               end else begin
                  state_q    <= T3;
                  stb_q.m1_l <= 1'b1;
                  if (op_q == OP_M1) begin
                     rdata_q <= D_in;
`ifdef Z80_BUS_RFSH_EN
                     stb_q.rd_l   <= 1'b1;
                     stb_q.rfsh_l <= 1'b0;
                     a_q          <= {8'h00, r_val};
`endif
                  end
               end
            end
            T3: begin
`ifdef Z80_BUS_RFSH_EN
               if (op_q == OP_M1) begin
                  state_q      <= T4;
                  stb_q.mreq_l <= 1'b1;
               end else
`endif
               begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  doe_q   <= 1'b0;
                  stb_q   <= STROBE_IDLE;
                  if ((op_q == OP_MEM_RD) || (op_q == OP_IO_RD)) begin
                     rdata_q <= D_in;
                  end
               end
            end
            T4: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               doe_q   <= 1'b0;
               stb_q   <= STROBE_IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign rdata  = rdata_q;
   assign A_out  = a_q;
   assign D_out  = dout_q;
   assign D_oe   = doe_q;
   assign MREQ_L = stb_q.mreq_l;
   assign IORQ_L = stb_q.iorq_l;
   assign RD_L   = stb_q.rd_l;
   assign WR_L   = stb_q.wr_l;
   assign M1_L   = stb_q.m1_l;
   assign RFSH_L = stb_q.rfsh_l;
   assign R_out  = r_val;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Scoreboard bench for z80_bus_ctrl: the driver pushes per-cycle expectations
// derived from T-state counts; a negedge monitor checks them at every done pulse.
module tb_z80_bus_ctrl;
   import z80_bus_pkg::*;

   localparam int unsigned AUTO = 1;
`ifdef Z80_BUS_RFSH_EN
   localparam bit RFSH = 1'b1;
`else
   localparam bit RFSH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, req, WAIT_L, ld_R;
   logic [2:0]  op;
   logic [15:0] addr_in;
   logic [7:0]  wdata, D_in, R_in;
   logic        busy, done, D_oe, MREQ_L, IORQ_L, RD_L, WR_L, M1_L, RFSH_L;
   logic [7:0]  rdata, D_out, R_out;
   logic [15:0] A_out;

   always #5 clk = ~clk;

   z80_bus_ctrl #(.IO_AUTO_WAIT(AUTO)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr_in(addr_in), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .A_out(A_out), .D_out(D_out),
      .D_oe(D_oe), .D_in(D_in), .WAIT_L(WAIT_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
      .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L), .RFSH_L(RFSH_L), .R_out(R_out),
      .ld_R(ld_R), .R_in(R_in)
   );

   typedef struct {
      int          lat;
      int          mreq, iorq, rd, wr, m1, doe, rfsh;
      logic [15:0] a_first, a_last;
      logic [7:0]  rdata, r, wdata;
      int          cyc0;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [7:0] m_rdata = 8'h00;
   logic [7:0] m_r = 8'h00;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: counts strobe-low cycles per transaction, compares at done.
   int          c_mreq, c_iorq, c_rd, c_wr, c_m1, c_doe, c_rfsh, c_dbad;
   logic [15:0] a_first, a_last;
   logic        prev_busy = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (busy && !prev_busy) begin
         {c_mreq, c_iorq, c_rd, c_wr, c_m1, c_doe, c_rfsh, c_dbad} = '0;
         a_first = A_out;
      end
      if (busy) a_last = A_out;
      c_mreq += int'(!MREQ_L); c_iorq += int'(!IORQ_L); c_rd   += int'(!RD_L);
      c_wr   += int'(!WR_L);   c_m1   += int'(!M1_L);   c_rfsh += int'(!RFSH_L);
      c_doe  += int'(D_oe);
      if (D_oe && sb.size() != 0 && D_out !== sb[0].wdata) c_dbad++;
      if (done) begin
         chk("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("latency", 32'(cyc - e.cyc0), 32'(e.lat));
            chk("rdata",   32'(rdata), 32'(e.rdata));
            chk("mreq_lo", 32'(c_mreq), 32'(e.mreq));
            chk("iorq_lo", 32'(c_iorq), 32'(e.iorq));
            chk("rd_lo",   32'(c_rd),   32'(e.rd));
            chk("wr_lo",   32'(c_wr),   32'(e.wr));
            chk("m1_lo",   32'(c_m1),   32'(e.m1));
            chk("rfsh_lo", 32'(c_rfsh), 32'(e.rfsh));
            chk("doe_hi",  32'(c_doe),  32'(e.doe));
            chk("dout_bad", 32'(c_dbad), 32'd0);
            chk("a_first", 32'(a_first), 32'(e.a_first));
            chk("a_last",  32'(a_last),  32'(e.a_last));
            chk("r_out",   32'(R_out),   32'(e.r));
         end
      end
      prev_busy = busy;
   end

   // Drive one transaction; entry and exit are at a negedge. Returns in the done cycle.
   task automatic issue(input bus_op_t o, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input int nwait, input bit junk_in,
                        input bit chain, input int ldm, input logic [7:0] rin);
      exp_t e;
      bit   io, rd, wr, rfm1, junk;
      int   au;
      logic [7:0] rb;
      junk = junk_in || chain;
      io   = (o == OP_IO_RD) || (o == OP_IO_WR);
      rd   = (o == OP_M1) || (o == OP_MEM_RD) || (o == OP_IO_RD);
      wr   = (o == OP_MEM_WR) || (o == OP_IO_WR);
      rfm1 = RFSH && (o == OP_M1);
      au   = io ? int'(AUTO) : 0;
      rb   = (ldm == 1) ? rin : m_r;
      e.lat  = 3 + au + nwait + int'(rfm1) + 1;
      e.mreq = io ? 0 : 3 + nwait;
      e.iorq = io ? 2 + au + nwait : 0;
      e.rd   = (o == OP_MEM_RD) ? 3 + nwait :
               (o == OP_M1)     ? (rfm1 ? 2 + nwait : 3 + nwait) :
               (o == OP_IO_RD)  ? 2 + au + nwait : 0;
      e.wr   = (o == OP_MEM_WR) ? 2 + nwait : (o == OP_IO_WR) ? 2 + au + nwait : 0;
      e.m1   = (o == OP_M1) ? 2 + nwait : 0;
      e.doe  = wr ? 3 + au + nwait : 0;
      e.rfsh = rfm1 ? 2 : 0;
      e.a_first = a;
      e.a_last  = rfm1 ? {8'h00, rb} : a;
      if (rd) m_rdata = din;
      e.rdata = m_rdata;
      if (!RFSH)          m_r = 8'h00;
      else if (ldm == 2)  m_r = rin;
      else if (rfm1)      m_r = {rb[7], 7'(rb[6:0] + 7'd1)};
      else                m_r = rb;
      e.r = m_r; e.wdata = wd; e.cyc0 = cyc;
      sb.push_back(e);
      req = 1'b1; op = o; addr_in = a; wdata = wd; D_in = din;
      ld_R = (ldm == 1); R_in = rin;
      @(negedge clk);
      ld_R = 1'b0; req = junk;
      if (junk) begin
         op = 3'($urandom_range(0, 4)); addr_in = 16'($urandom); wdata = 8'($urandom);
      end
      repeat (1 + au) @(negedge clk);
      for (int j = 0; j < nwait; j++) begin
         WAIT_L = 1'b0;
         @(negedge clk);
      end
      WAIT_L = 1'b1;
      @(negedge clk);
      if (rfm1) @(negedge clk);
      if (ldm == 2) ld_R = 1'b1;
      @(negedge clk);
      ld_R = 1'b0;
      if (!chain) req = 1'b0;
   endtask

   initial begin
      bus_op_t o;
      bit      ch;
      rst = 1'b1; req = 1'b0; op = 3'd0; addr_in = 16'h0; wdata = 8'h0;
      D_in = 8'h0; WAIT_L = 1'b1; ld_R = 1'b0; R_in = 8'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);   chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0); chk("rst_a", 32'(A_out), 32'd0);
      chk("rst_dout", 32'(D_out), 32'd0);  chk("rst_doe", 32'(D_oe), 32'd0);
      chk("rst_strobes", 32'({MREQ_L, IORQ_L, RD_L, WR_L, M1_L, RFSH_L}), 32'h3F);
      chk("rst_r", 32'(R_out), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(OP_MEM_RD, 16'hFEED, 8'h00, 8'hBA, 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      issue(OP_MEM_WR, 16'h1234, 8'h5A, 8'hC3, 2, 0, 0, 0, 8'h00);
      @(negedge clk);
      issue(OP_IO_RD, 16'h00FE, 8'h00, 8'h3C, 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      issue(OP_MEM_RD, 16'h4000, 8'h00, 8'h11, 0, 1, 1, 0, 8'h00);
      issue(OP_MEM_RD, 16'h4001, 8'h00, 8'h22, 0, 1, 0, 0, 8'h00);

      // Reset during a TW of a write aborts without a done pulse.
      @(negedge clk);
      req = 1'b1; op = OP_MEM_WR; addr_in = 16'hBEEF; wdata = 8'h77;
      @(negedge clk); req = 1'b0;
      @(negedge clk); WAIT_L = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("abort_strobes", 32'({MREQ_L, IORQ_L, RD_L, WR_L, M1_L, RFSH_L}), 32'h3F);
      chk("abort_doe", 32'(D_oe), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      rst = 1'b0; WAIT_L = 1'b1; m_rdata = 8'h00; m_r = 8'h00;
      repeat (2) @(negedge clk);

      issue(OP_M1, 16'h8000, 8'h00, 8'h3E, 0, 0, 0, 1, 8'hFF);
      @(negedge clk);

      for (int t = 0; t < 40; t++) begin
         o  = bus_op_t'(3'($urandom_range(0, 4)));
         ch = (t < 39) && ($urandom_range(0, 3) == 0);
         issue(o, 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), ch,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0, 8'($urandom));
         if (!ch) repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int k = 0; k < 64 && sb.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
